pipe_ctrl_hazard_unit: RTL and testbench
========================================

Name: pipe_ctrl_hazard_unit

Overview:
Successor to the combinational control decoder. Decodes the ID-stage instruction and registers the control word into the ID/EX pipeline register. Detects load-use and multiply/divide hazards, and generates stall, flush and bubble signals. Tracks an iterative MULT/DIV unit with a busy counter; sits between the IF/ID register and the EX stage.

Parameters:
ALUOP_W, 4, ALUOp width; all-ones means "R-type, decode from FuncCode"
MD_LATENCY, 32, EX cycles a MULT/DIV occupies the HI/LO unit (>=1)
REG_AW, 5, register-specifier width

Ports:
CLK  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high
IdInstr  in  32  instruction in IF/ID
IdValid  in  1  IF/ID holds a real instruction
BranchTaken  in  1  branch resolved taken in EX this cycle
PCWrite  out  1  PC may advance (comb)
IFIDWrite  out  1  IF/ID may load (comb)
IFIDFlush  out  1  IF/ID cleared at next edge (comb)
Jump  out  1  ID holds valid J (comb)
MdBusy  out  1  HI/LO unit busy (reg-derived)
ExRegDst, ExUseImmed, ExUseShamt, ExSignExtend, ExMemToReg, ExRegWrite, ExMemRead, ExMemWrite, ExBranch, ExMdStart  out  1 each  ID/EX control
ExMdOp  out  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
ExALUOp  out  ALUOP_W  ID/EX ALU op
ExRs, ExRt, ExWriteReg  out  REG_AW each  ID/EX specifiers

Behaviour:
- Reset: every Ex* output 0, busy counter 0, MdBusy 0. Comb outputs follow the rules below.
- Decode covers R-type, LW, SW, BEQ, J, ORI, ADDI, ADDIU, ANDI, LUI, SLTI, SLTIU and XORI, with the same control values as the current decoder. UseShamt is set only for SLL/SRL/SRA.
- ExWriteReg = RegDst ? rd : rt. MFHI/MFLO are R-type writes to rd. MULT/DIV: RegWrite=0, ExMdStart=1.
- UsesRs: all except J, LUI, SLL/SRL/SRA, MFHI, MFLO.
- UsesRt: R-type except MFHI/MFLO/MULT*/DIV* (those MULT*/DIV* do use rt), plus SW and BEQ.
- LoadUse = ExMemRead & ExRt!=0 & ((UsesRs & ExRt==rs) | (UsesRt & ExRt==rt)).
- MdHaz = MdBusy & (ID is MFHI/MFLO/MULT*/DIV*).
- Stall = IdValid & (LoadUse | MdHaz) & ~BranchTaken.
- Priority, highest first:
  - BranchTaken: PCWrite=1, IFIDWrite=1, IFIDFlush=1, ID/EX loads bubble.
  - Stall: PCWrite=0, IFIDWrite=0, IFIDFlush=0, ID/EX loads bubble.
  - ~IdValid: bubble, PCWrite=IFIDWrite=1.
  - Otherwise: ID/EX loads the decoded word, PCWrite=IFIDWrite=1. If J: Jump=1, IFIDFlush=1.
- Bubble: all Ex* fields 0.
- Latency: one edge from ID decode to Ex* outputs.
- Busy counter, width clog2(MD_LATENCY+1):
  - Loads MD_LATENCY at the edge where a MULT/DIV is latched (not bubbled) into ID/EX.
  - Otherwise decrements when nonzero; saturates at 0.
  - MdBusy = counter!=0.
- MULT/DIV killed by BranchTaken or stall: never loads the counter.
- Reset mid-operation: counter and ID/EX cleared immediately; no residual stall.
- Illegal opcode: bubble-equivalent control word, no stall.

Optional Feature:
CTRL_MULTDIV_EN.
- Defined: MULT/MULTU/DIV/DIVU/MFHI/MFLO decoded, busy counter and MdHaz present.
- Undefined: those functs decode as illegal (all control 0). Counter removed, MdBusy tied 0, ExMdStart/ExMdOp tied 0, MD_LATENCY ignored.

Decomposition:
- Package ctrl_pkg: opcode constants, funct constants (including MULT/DIV/MFHI/MFLO), ALUOp codes, RTYPE_ALUOP, MdOp encodings, control-word struct and its BUBBLE constant.
- Sub-module md_busy_tracker: counter load/decrement and MdBusy.
- Hazard logic and decode stay in the top level.

Test Plan:
1. Reset asserted mid-MULT (counter=17) -> all Ex* 0 and MdBusy 0 asynchronously; PCWrite=1 with IdValid=0.
2. LW $2,0($1) then ADD $3,$2,$4 -> exactly one cycle PCWrite=IFIDWrite=0 with bubble in ID/EX; ADD then enters EX with ExWriteReg=3, ExRegWrite=1.
3. LW $0,0($1) then ADD $3,$0,$4 -> no stall; SLL $5,$2,3 after LW $2 -> stall (rt use); LUI $2 after LW $2 -> no stall.
4. MD_LATENCY=4: MULT $1,$2 then MFLO $3 -> ExMdStart=1 for one cycle; MFLO stalled 4 cycles; enters EX the edge after counter reaches 0.
5. BranchTaken=1 in the same cycle as a LoadUse -> PCWrite=1, IFIDFlush=1, bubble; a MULT in ID under BranchTaken leaves MdBusy=0.
6. J 0x100 with IdValid=1 -> Jump=1, IFIDFlush=1, ExRegWrite=0. Build without CTRL_MULTDIV_EN: MFHI yields all-zero control and MdBusy stays 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared decode constants and the ID/EX control-word layout for pipe_ctrl_hazard_unit.
// MULT/DIV/MFHI/MFLO functs are always listed here; the top decides whether they are legal.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;

  localparam int CTRL_ALUOP_W = 4;
  typedef logic [CTRL_ALUOP_W-1:0] aluop_t;

  localparam aluop_t ALUOP_ADD   = 4'd0;
  localparam aluop_t ALUOP_SUB   = 4'd1;
  localparam aluop_t ALUOP_AND   = 4'd2;
  localparam aluop_t ALUOP_OR    = 4'd3;
  localparam aluop_t ALUOP_XOR   = 4'd4;
  localparam aluop_t ALUOP_SLT   = 4'd5;
  localparam aluop_t ALUOP_SLTU  = 4'd6;
  localparam aluop_t ALUOP_LUI   = 4'd7;
  localparam aluop_t RTYPE_ALUOP = 4'hf;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } mdop_e;

  typedef struct packed {
    logic       reg_dst;
    logic       use_immed;
    logic       use_shamt;
    logic       sign_extend;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       md_start;
    mdop_e      md_op;
    aluop_t     alu_op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] write_reg;
  } ctrl_t;

  localparam ctrl_t BUBBLE = '0;

  // Low two funct bits of MULT/MULTU/DIV/DIVU line up with the MdOp encoding.
  function automatic mdop_e md_op_of(input logic [5:0] funct);
    return mdop_e'(funct[1:0]);
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_unit_if.sv
// ID-stage instruction in, hazard controls and registered ID/EX control word out.
// master drives the instruction side; slave is the hazard unit.
interface pipe_ctrl_hazard_unit_if #(
  parameter int ALUOP_W = 4,
  parameter int REG_AW  = 5
);
  logic [31:0]        IdInstr;
  logic               IdValid;
  logic               BranchTaken;

  logic               PCWrite;
  logic               IFIDWrite;
  logic               IFIDFlush;
  logic               Jump;
  logic               MdBusy;

  logic               ExRegDst;
  logic               ExUseImmed;
  logic               ExUseShamt;
  logic               ExSignExtend;
  logic               ExMemToReg;
  logic               ExRegWrite;
  logic               ExMemRead;
  logic               ExMemWrite;
  logic               ExBranch;
  logic               ExMdStart;
  logic [1:0]         ExMdOp;
  logic [ALUOP_W-1:0] ExALUOp;
  logic [REG_AW-1:0]  ExRs;
  logic [REG_AW-1:0]  ExRt;
  logic [REG_AW-1:0]  ExWriteReg;

  modport master (
    output IdInstr, IdValid, BranchTaken,
    input  PCWrite, IFIDWrite, IFIDFlush, Jump, MdBusy,
    input  ExRegDst, ExUseImmed, ExUseShamt, ExSignExtend, ExMemToReg,
    input  ExRegWrite, ExMemRead, ExMemWrite, ExBranch, ExMdStart,
    input  ExMdOp, ExALUOp, ExRs, ExRt, ExWriteReg
  );

  modport slave (
    input  IdInstr, IdValid, BranchTaken,
    output PCWrite, IFIDWrite, IFIDFlush, Jump, MdBusy,
    output ExRegDst, ExUseImmed, ExUseShamt, ExSignExtend, ExMemToReg,
    output ExRegWrite, ExMemRead, ExMemWrite, ExBranch, ExMdStart,
    output ExMdOp, ExALUOp, ExRs, ExRt, ExWriteReg
  );
endinterface

// File: rtl/md_busy_tracker.sv
// HI/LO occupancy counter: loads MD_LATENCY when a MULT/DIV enters EX, then counts down to 0.
// busy_o is derived from the registered count, so it rises the cycle after the load edge.
module md_busy_tracker #(
  parameter int MD_LATENCY = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  output logic busy_o
);
  localparam int                CNT_W    = $clog2(MD_LATENCY + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MD_LATENCY);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/pipe_ctrl_hazard_unit.sv
// ID decode plus load-use / HI-LO / branch / jump hazard control; one edge from ID to the Ex* word.
// CTRL_MULTDIV_EN enables MULT/DIV/MFHI/MFLO decode and the HI/LO busy tracker.
module pipe_ctrl_hazard_unit
  import ctrl_pkg::*;
#(
  parameter int ALUOP_W    = 4,
  parameter int MD_LATENCY = 32,
  parameter int REG_AW     = 5
) (
  input  logic                   CLK,
  input  logic                   Reset,
  pipe_ctrl_hazard_unit_if.slave bus
);

  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd;
  logic       unused_shamt;

  assign opcode       = bus.IdInstr[31:26];
  assign rs           = bus.IdInstr[25:21];
  assign rt           = bus.IdInstr[20:16];
  assign rd           = bus.IdInstr[15:11];
  assign funct        = bus.IdInstr[5:0];
  assign unused_shamt = ^bus.IdInstr[10:6];

  ctrl_t dec;
  logic  legal, is_jump, uses_rs, uses_rt;
`ifdef CTRL_MULTDIV_EN
  logic  is_md_class;
`endif

  always_comb begin
    dec     = BUBBLE;
    legal   = 1'b1;
    is_jump = 1'b0;
    uses_rs = 1'b0;
    uses_rt = 1'b0;
`ifdef CTRL_MULTDIV_EN
    is_md_class = 1'b0;
`endif
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_SLL, F_SRL, F_SRA: begin
            dec.reg_dst   = 1'b1;
            dec.reg_write = 1'b1;
            dec.use_shamt = 1'b1;
            dec.alu_op    = RTYPE_ALUOP;
            uses_rt       = 1'b1;
          end
`ifdef CTRL_MULTDIV_EN
          F_MFHI, F_MFLO: begin
            dec.reg_dst   = 1'b1;
            dec.reg_write = 1'b1;
            dec.alu_op    = RTYPE_ALUOP;
            is_md_class   = 1'b1;
          end
          F_MULT, F_MULTU, F_DIV, F_DIVU: begin
            dec.reg_dst  = 1'b1;
            dec.md_start = 1'b1;
            dec.md_op    = md_op_of(funct);
            dec.alu_op   = RTYPE_ALUOP;
            uses_rs      = 1'b1;
            uses_rt      = 1'b1;
            is_md_class  = 1'b1;
          end
`else
          F_MFHI, F_MFLO, F_MULT, F_MULTU, F_DIV, F_DIVU: begin
            legal = 1'b0;
          end
`endif
          default: begin
            dec.reg_dst   = 1'b1;
            dec.reg_write = 1'b1;
            dec.alu_op    = RTYPE_ALUOP;
            uses_rs       = 1'b1;
            uses_rt       = 1'b1;
          end
        endcase
      end
      OP_LW: begin
        dec.use_immed   = 1'b1;
        dec.sign_extend = 1'b1;
        dec.mem_to_reg  = 1'b1;
        dec.reg_write   = 1'b1;
        dec.mem_read    = 1'b1;
        dec.alu_op      = ALUOP_ADD;
        uses_rs         = 1'b1;
      end
      OP_SW: begin
        dec.use_immed   = 1'b1;
        dec.sign_extend = 1'b1;
        dec.mem_write   = 1'b1;
        dec.alu_op      = ALUOP_ADD;
        uses_rs         = 1'b1;
        uses_rt         = 1'b1;
      end
      OP_BEQ: begin
        dec.sign_extend = 1'b1;
        dec.branch      = 1'b1;
        dec.alu_op      = ALUOP_SUB;
        uses_rs         = 1'b1;
        uses_rt         = 1'b1;
      end
      OP_J: begin
        is_jump = 1'b1;
      end
      OP_ADDI, OP_ADDIU: begin
        dec.use_immed   = 1'b1;
        dec.sign_extend = 1'b1;
        dec.reg_write   = 1'b1;
        dec.alu_op      = ALUOP_ADD;
        uses_rs         = 1'b1;
      end
      OP_SLTI, OP_SLTIU: begin
        dec.use_immed   = 1'b1;
        dec.sign_extend = 1'b1;
        dec.reg_write   = 1'b1;
        dec.alu_op      = (opcode == OP_SLTI) ? ALUOP_SLT : ALUOP_SLTU;
        uses_rs         = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        dec.use_immed = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = (opcode == OP_ANDI) ? ALUOP_AND :
                        (opcode == OP_ORI)  ? ALUOP_OR  : ALUOP_XOR;
        uses_rs       = 1'b1;
      end
      OP_LUI: begin
        dec.use_immed = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = ALUOP_LUI;
      end
      default: begin
        legal = 1'b0;
      end
    endcase

    // J does no EX work and illegal opcodes must look like bubbles, so neither carries specifiers.
    if (legal && !is_jump) begin
      dec.rs        = rs;
      dec.rt        = rt;
      dec.write_reg = dec.reg_dst ? rd : rt;
    end
  end

  ctrl_t ex_q, ex_d;
  logic  md_busy, md_haz, load_use, stall;
  logic  pc_write, ifid_write, ifid_flush, jump;

  assign load_use = ex_q.mem_read && (ex_q.rt != 5'd0) &&
                    ((uses_rs && (ex_q.rt == rs)) || (uses_rt && (ex_q.rt == rt)));
  assign stall    = bus.IdValid && (load_use || md_haz) && !bus.BranchTaken;

  always_comb begin
    ex_d       = BUBBLE;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    jump       = 1'b0;
    if (bus.BranchTaken) begin
      ifid_flush = 1'b1;
    end else if (stall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (bus.IdValid) begin
      ex_d = dec;
      if (is_jump) begin
        jump       = 1'b1;
        ifid_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      ex_q <= BUBBLE;
    end else begin
      ex_q <= ex_d;
    end
  end

`ifdef CTRL_MULTDIV_EN
  // ex_d.md_start is only set when a MULT/DIV survives branch and stall into ID/EX.
  md_busy_tracker #(
    .MD_LATENCY (MD_LATENCY)
  ) u_md_busy (
    .clk_i  (CLK),
    .rst_i  (Reset),
    .load_i (ex_d.md_start),
    .busy_o (md_busy)
  );

  assign md_haz        = md_busy && is_md_class;
  assign bus.ExMdStart = ex_q.md_start;
  assign bus.ExMdOp    = ex_q.md_op;
`else
  localparam int unused_md_latency = MD_LATENCY;
  logic unused_md_fields;

  assign md_busy          = 1'b0;
  assign md_haz           = 1'b0;
  assign unused_md_fields = ^{ex_q.md_start, ex_q.md_op};
  assign bus.ExMdStart    = 1'b0;
  assign bus.ExMdOp       = 2'b00;
`endif

  assign bus.PCWrite   = pc_write;
  assign bus.IFIDWrite = ifid_write;
  assign bus.IFIDFlush = ifid_flush;
  assign bus.Jump      = jump;
  assign bus.MdBusy    = md_busy;

  assign bus.ExRegDst     = ex_q.reg_dst;
  assign bus.ExUseImmed   = ex_q.use_immed;
  assign bus.ExUseShamt   = ex_q.use_shamt;
  assign bus.ExSignExtend = ex_q.sign_extend;
  assign bus.ExMemToReg   = ex_q.mem_to_reg;
  assign bus.ExRegWrite   = ex_q.reg_write;
  assign bus.ExMemRead    = ex_q.mem_read;
  assign bus.ExMemWrite   = ex_q.mem_write;
  assign bus.ExBranch     = ex_q.branch;
  assign bus.ExALUOp      = (ex_q.alu_op == RTYPE_ALUOP) ? {ALUOP_W{1'b1}} : ALUOP_W'(ex_q.alu_op);
  assign bus.ExRs         = REG_AW'(ex_q.rs);
  assign bus.ExRt         = REG_AW'(ex_q.rt);
  assign bus.ExWriteReg   = REG_AW'(ex_q.write_reg);

endmodule

// File: tb/tb_pipe_ctrl_hazard_unit.sv
// Directed bench for pipe_ctrl_hazard_unit: two instances (MD_LATENCY 32 and 4) share stimulus.
// Expectations track CTRL_MULTDIV_EN so the same vectors cover both builds.
module tb_pipe_ctrl_hazard_unit;

  logic CLK = 1'b0;
  logic Reset;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errs   = 0;

`ifdef CTRL_MULTDIV_EN
  localparam logic MD_EN = 1'b1;
`else
  localparam logic MD_EN = 1'b0;
`endif

  localparam logic [5:0] T_LW = 6'h23, T_LUI = 6'h0f, T_ADDI = 6'h08, T_J = 6'h02, T_BAD = 6'h3f;
  localparam logic [5:0] T_ADD = 6'h20, T_SLL = 6'h00, T_MFHI = 6'h10, T_MFLO = 6'h12, T_MULT = 6'h18;

  pipe_ctrl_hazard_unit_if #(.ALUOP_W(4), .REG_AW(5)) bus32 ();
  pipe_ctrl_hazard_unit_if #(.ALUOP_W(4), .REG_AW(5)) bus4 ();

  pipe_ctrl_hazard_unit u_dut32 (.CLK(CLK), .Reset(Reset), .bus(bus32));
  pipe_ctrl_hazard_unit #(.MD_LATENCY(4)) u_dut4 (.CLK(CLK), .Reset(Reset), .bus(bus4));

  logic [31:0] ex_all32, ex_all4;
  assign ex_all32 = {1'b0, bus32.ExRegDst, bus32.ExUseImmed, bus32.ExUseShamt, bus32.ExSignExtend,
                     bus32.ExMemToReg, bus32.ExRegWrite, bus32.ExMemRead, bus32.ExMemWrite,
                     bus32.ExBranch, bus32.ExMdStart, bus32.ExMdOp, bus32.ExALUOp,
                     bus32.ExRs, bus32.ExRt, bus32.ExWriteReg};
  assign ex_all4  = {1'b0, bus4.ExRegDst, bus4.ExUseImmed, bus4.ExUseShamt, bus4.ExSignExtend,
                     bus4.ExMemToReg, bus4.ExRegWrite, bus4.ExMemRead, bus4.ExMemWrite,
                     bus4.ExBranch, bus4.ExMdStart, bus4.ExMdOp, bus4.ExALUOp,
                     bus4.ExRs, bus4.ExRt, bus4.ExWriteReg};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] s, input logic [4:0] t,
                                        input logic [4:0] d, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, s, t, d, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] s,
                                        input logic [4:0] t, input logic [15:0] imm);
    return {op, s, t, imm};
  endfunction

  task automatic drive(input logic [31:0] ins, input logic v, input logic br);
    bus32.IdInstr = ins; bus32.IdValid = v; bus32.BranchTaken = br;
    bus4.IdInstr  = ins; bus4.IdValid  = v; bus4.BranchTaken  = br;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] lw2, add_r2, mult12;
    int stalls;
    lw2    = enc_i(T_LW, 5'd1, 5'd2, 16'h0000);
    add_r2 = enc_r(5'd2, 5'd4, 5'd3, 5'd0, T_ADD);
    mult12 = enc_r(5'd1, 5'd2, 5'd0, 5'd0, T_MULT);

    Reset = 1'b1;
    drive(32'h0, 1'b0, 1'b0);
    chk("rst_ex_word", ex_all4, 32'h0);
    chk("rst_mdbusy", 32'(bus4.MdBusy), 0);
    chk("rst_pcwrite", 32'(bus4.PCWrite), 1);
    chk("rst_ifidwrite", 32'(bus4.IFIDWrite), 1);
    chk("rst_flush", 32'(bus4.IFIDFlush), 0);
    @(negedge CLK);
    Reset = 1'b0;

    // Load-use on rs: one bubble, then ADD proceeds.
    drive(lw2, 1'b1, 1'b0);
    chk("lw_no_stall", 32'(bus4.PCWrite), 1);
    tick();
    drive(add_r2, 1'b1, 1'b0);
    chk("lu_pcwrite", 32'(bus4.PCWrite), 0);
    chk("lu_ifidwrite", 32'(bus4.IFIDWrite), 0);
    chk("lu_flush", 32'(bus4.IFIDFlush), 0);
    chk("lw_memread", 32'(bus4.ExMemRead), 1);
    chk("lw_memtoreg", 32'(bus4.ExMemToReg), 1);
    chk("lw_writereg", 32'(bus4.ExWriteReg), 2);
    chk("lw_signext", 32'(bus4.ExSignExtend), 1);
    chk("lw_aluop", 32'(bus4.ExALUOp), 0);
    tick();
    chk("lu_bubble", ex_all4, 32'h0);
    chk("lu_release", 32'(bus4.PCWrite), 1);
    tick();
    chk("add_writereg", 32'(bus4.ExWriteReg), 3);
    chk("add_regwrite", 32'(bus4.ExRegWrite), 1);
    chk("add_regdst", 32'(bus4.ExRegDst), 1);
    chk("add_aluop", 32'(bus4.ExALUOp), 32'hf);
    chk("add_rs", 32'(bus4.ExRs), 2);
    chk("add_rt", 32'(bus4.ExRt), 4);

    // $0 never creates a hazard; SLL uses rt; LUI uses neither.
    drive(enc_i(T_LW, 5'd1, 5'd0, 16'h0000), 1'b1, 1'b0);
    tick();
    drive(enc_r(5'd0, 5'd4, 5'd3, 5'd0, T_ADD), 1'b1, 1'b0);
    chk("r0_no_stall", 32'(bus4.PCWrite), 1);
    tick();
    drive(lw2, 1'b1, 1'b0);
    tick();
    drive(enc_r(5'd0, 5'd2, 5'd5, 5'd3, T_SLL), 1'b1, 1'b0);
    chk("sll_stall", 32'(bus4.PCWrite), 0);
    tick();
    chk("sll_release", 32'(bus4.PCWrite), 1);
    tick();
    chk("sll_shamt", 32'(bus4.ExUseShamt), 1);
    chk("sll_writereg", 32'(bus4.ExWriteReg), 5);
    drive(lw2, 1'b1, 1'b0);
    tick();
    drive(enc_i(T_LUI, 5'd0, 5'd2, 16'h1234), 1'b1, 1'b0);
    chk("lui_no_stall", 32'(bus4.PCWrite), 1);
    tick();
    chk("lui_aluop", 32'(bus4.ExALUOp), 7);
    chk("lui_immed", 32'(bus4.ExUseImmed), 1);
    chk("lui_writereg", 32'(bus4.ExWriteReg), 2);
    chk("lui_signext", 32'(bus4.ExSignExtend), 0);

    // Branch overrides load-use; a MULT killed by the branch never starts the counter.
    drive(lw2, 1'b1, 1'b0);
    tick();
    drive(add_r2, 1'b1, 1'b1);
    chk("br_pcwrite", 32'(bus4.PCWrite), 1);
    chk("br_ifidwrite", 32'(bus4.IFIDWrite), 1);
    chk("br_flush", 32'(bus4.IFIDFlush), 1);
    tick();
    chk("br_bubble", ex_all4, 32'h0);
    drive(mult12, 1'b1, 1'b1);
    tick();
    drive(32'h0, 1'b0, 1'b0);
    chk("br_mult_start", 32'(bus4.ExMdStart), 0);
    chk("br_mult_busy", 32'(bus4.MdBusy), 0);
    tick();
    chk("br_mult_busy2", 32'(bus4.MdBusy), 0);

    // Jump, then illegal opcode after a load.
    drive({T_J, 26'h0000040}, 1'b1, 1'b0);
    chk("j_jump", 32'(bus4.Jump), 1);
    chk("j_flush", 32'(bus4.IFIDFlush), 1);
    chk("j_pcwrite", 32'(bus4.PCWrite), 1);
    tick();
    drive({T_J, 26'h0000040}, 1'b0, 1'b0);
    chk("j_regwrite", 32'(bus4.ExRegWrite), 0);
    chk("j_invalid_nojump", 32'(bus4.Jump), 0);
    drive(lw2, 1'b1, 1'b0);
    tick();
    drive(enc_i(T_BAD, 5'd2, 5'd2, 16'h0000), 1'b1, 1'b0);
    chk("illegal_no_stall", 32'(bus4.PCWrite), 1);
    tick();
    chk("illegal_bubble", ex_all4, 32'h0);

    drive(enc_r(5'd0, 5'd0, 5'd3, 5'd0, T_MFHI), 1'b1, 1'b0);
    chk("mfhi_no_stall", 32'(bus4.PCWrite), 1);
    tick();
    drive(32'h0, 1'b0, 1'b0);
    chk("mfhi_regwrite", 32'(bus4.ExRegWrite), 32'(MD_EN));
    chk("mfhi_writereg", 32'(bus4.ExWriteReg), MD_EN ? 32'd3 : 32'd0);
    chk("mfhi_mdbusy", 32'(bus4.MdBusy), 0);

    // Reset mid-MULT on the 32-cycle instance with the counter at 17.
    drive(mult12, 1'b1, 1'b0);
    tick();
    drive(32'h0, 1'b0, 1'b0);
    repeat (14) tick();
    drive(enc_i(T_ADDI, 5'd1, 5'd5, 16'h0007), 1'b1, 1'b0);
    tick();
    drive(32'h0, 1'b0, 1'b0);
    chk("prerst_busy", 32'(bus32.MdBusy), 32'(MD_EN));
    chk("prerst_regwrite", 32'(bus32.ExRegWrite), 1);
    Reset = 1'b1;
    #1;
    chk("arst_ex_word", ex_all32, 32'h0);
    chk("arst_mdbusy", 32'(bus32.MdBusy), 0);
    chk("arst_pcwrite", 32'(bus32.PCWrite), 1);
    #1;
    Reset = 1'b0;
    tick();
    chk("postrst_busy", 32'(bus32.MdBusy), 0);
    drive(enc_r(5'd0, 5'd0, 5'd3, 5'd0, T_MFHI), 1'b1, 1'b0);
    chk("postrst_no_stall", 32'(bus32.PCWrite), 1);
    tick();
    drive(32'h0, 1'b0, 1'b0);

    // MULT then MFLO on the MD_LATENCY=4 instance.
    drive(mult12, 1'b1, 1'b0);
    tick();
    drive(enc_r(5'd0, 5'd0, 5'd3, 5'd0, T_MFLO), 1'b1, 1'b0);
    chk("md_start", 32'(bus4.ExMdStart), 32'(MD_EN));
    chk("md_busy_set", 32'(bus4.MdBusy), 32'(MD_EN));
    chk("md_mult_regwrite", 32'(bus4.ExRegWrite), 0);
    stalls = 0;
    while (bus4.PCWrite == 1'b0 && stalls < 10) begin
      stalls++;
      tick();
      if (stalls == 1) chk("md_start_once", 32'(bus4.ExMdStart), 0);
    end
    chk("md_stall_cycles", 32'(stalls), MD_EN ? 32'd4 : 32'd0);
    chk("md_release_busy", 32'(bus4.MdBusy), 0);
    tick();
    drive(32'h0, 1'b0, 1'b0);
    chk("mflo_regwrite", 32'(bus4.ExRegWrite), 32'(MD_EN));
    chk("mflo_writereg", 32'(bus4.ExWriteReg), MD_EN ? 32'd3 : 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
